// File: rtl/adc_frame_buffer.sv
// adc_frame_buffer
//   Paces the ADC SPI reader with a periodic SAMPLE strobe, captures each
//   completed ADC word (on the rising edge of the reader's DV level) into a
//   2**ADDR_WIDTH-entry frame memory, and holds the full frame for the FFT
//   stage until it is released with FRAME_DONE.
//
//   Optional feature (compile-time macro SIGNED_SAMPLES_EN):
//     defined   - stored word has its MSB inverted (offset-binary to two's
//                 complement, DC-centred samples for the FFT)
//     undefined - ADC_DATA stored unmodified
//
// Ports
//   CLOCK        in   system clock, single domain
//   RESET        in   synchronous, active-high reset
//   ADC_DATA     in   reader DATA_OUT word
//   ADC_DV       in   reader data-valid level (may stay high several cycles)
//   SAMPLE       out  one-cycle conversion-start strobe to the reader
//   RD_ADDR      in   FFT read address
//   RD_DATA      out  frame word at RD_ADDR, one cycle latency
//   FRAME_READY  out  frame full and held
//   FRAME_DONE   in   one-cycle release pulse from the FFT
//   OVERFLOW     out  sticky: a completed sample was dropped while holding a frame
module adc_frame_buffer #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 5,
    parameter int SAMPLE_PERIOD = 64
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] ADC_DATA,
    input  logic                  ADC_DV,
    output logic                  SAMPLE,
    input  logic [ADDR_WIDTH-1:0] RD_ADDR,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  FRAME_READY,
    input  logic                  FRAME_DONE,
    output logic                  OVERFLOW
);

    localparam int FRAME_LEN = 2 ** ADDR_WIDTH;
    localparam int TIMER_W   = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [TIMER_W-1:0]    TIMER_LAST = TIMER_W'(SAMPLE_PERIOD - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = {ADDR_WIDTH{1'b1}};

    typedef enum logic {
        CAPTURE = 1'b0,
        READY   = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr;
    logic [TIMER_W-1:0]      timer;
    logic                    dv_q;
    logic                    cap_evt;
    logic                    wr_en;
    logic                    sample_q;
    logic                    overflow_q;
    logic [DATA_WIDTH-1:0]   rd_data_p1;
    logic [DATA_WIDTH-1:0]   mem [FRAME_LEN];

    function automatic logic [DATA_WIDTH-1:0] to_stored_word(input logic [DATA_WIDTH-1:0] w);
`ifdef SIGNED_SAMPLES_EN
        return {~w[DATA_WIDTH-1], w[DATA_WIDTH-2:0]};
`else
        return w;
`endif
    endfunction

    // A DV level held across many cycles yields exactly one capture.
    assign cap_evt = ADC_DV & ~dv_q;

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        case (state_q)
            CAPTURE: begin
                // FRAME_DONE is deliberately ignored here, even on the final write.
                if (cap_evt) begin
                    wr_en = 1'b1;
                    if (wr_ptr == LAST_ADDR) begin
                        state_d = READY;
                    end
                end
            end
            READY: begin
                if (FRAME_DONE) begin
                    state_d = CAPTURE;
                end
            end
            default: state_d = CAPTURE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q    <= CAPTURE;
            wr_ptr     <= '0;
            timer      <= '0;
            sample_q   <= 1'b0;
            overflow_q <= 1'b0;
            // Treat DV as already high so a level present at release is not captured.
            dv_q       <= 1'b1;
        end else begin
            state_q <= state_d;
            dv_q    <= ADC_DV;
            // wr_ptr wraps naturally to 0 on the final write of a frame.
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (state_q == CAPTURE) begin
                if (timer == TIMER_LAST) begin
                    timer    <= '0;
                    sample_q <= 1'b1;
                end else begin
                    timer    <= timer + 1'b1;
                    sample_q <= 1'b0;
                end
            end else begin
                timer    <= '0;
                sample_q <= 1'b0;
            end
            // Release clears the flag even if a capture lands in the same cycle.
            if (state_q == READY) begin
                if (FRAME_DONE) begin
                    overflow_q <= 1'b0;
                end else if (cap_evt) begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    // Frame memory: single synchronous write port
    always_ff @(posedge CLOCK) begin
        if (wr_en) begin
            mem[wr_ptr] <= to_stored_word(ADC_DATA);
        end
    end

    // Registered read port, one cycle latency
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            rd_data_p1 <= '0;
        end else begin
            rd_data_p1 <= mem[RD_ADDR];
        end
    end

    assign SAMPLE      = sample_q;
    assign FRAME_READY = (state_q == READY);
    assign OVERFLOW    = overflow_q;
    assign RD_DATA     = rd_data_p1;

endmodule

// File: tb/tb_adc_frame_buffer.sv
// tb_adc_frame_buffer
//   Drives adc_frame_buffer (ADDR_WIDTH=3, SAMPLE_PERIOD=64) with a behavioural
//   ADC that answers each SAMPLE strobe with a DV level 43 cycles later, and
//   compares outputs against a frame-level reference model (expected frame
//   array, fill count, ready and overflow flags).
module tb_adc_frame_buffer;

    localparam int DW  = 8;
    localparam int AW  = 3;
    localparam int LEN = 8;
    localparam int SP  = 64;

    logic          CLOCK = 1'b0;
    logic          RESET = 1'b1;
    logic [DW-1:0] ADC_DATA = '0;
    logic          ADC_DV = 1'b0;
    logic          SAMPLE;
    logic [AW-1:0] RD_ADDR = '0;
    logic [DW-1:0] RD_DATA;
    logic          FRAME_READY;
    logic          FRAME_DONE = 1'b0;
    logic          OVERFLOW;

    adc_frame_buffer #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .SAMPLE_PERIOD(SP)
    ) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .ADC_DATA   (ADC_DATA),
        .ADC_DV     (ADC_DV),
        .SAMPLE     (SAMPLE),
        .RD_ADDR    (RD_ADDR),
        .RD_DATA    (RD_DATA),
        .FRAME_READY(FRAME_READY),
        .FRAME_DONE (FRAME_DONE),
        .OVERFLOW   (OVERFLOW)
    );

    always #5 CLOCK = ~CLOCK;

    int          n_cmp = 0;
    int          n_err = 0;
    int          since = 0;
    logic [DW-1:0] exp_mem [LEN];
    logic [DW-1:0] vals [LEN];
    int          exp_cnt = 0;
    bit          exp_ready = 1'b0;
    bit          exp_ovf = 1'b0;

    function automatic logic [DW-1:0] stored(input logic [DW-1:0] v);
`ifdef SIGNED_SAMPLES_EN
        return v ^ 8'h80;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
        since++;
    endtask

    task automatic wait_sample();
        int n;
        n = 0;
        while (SAMPLE !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("sample_timeout", {31'd0, SAMPLE}, 32'd1);
        else          chk("sample_gap", since, SP);
        since = 0;
    endtask

    task automatic check_flags(input string where);
        chk({where, "_ready"}, {31'd0, FRAME_READY}, {31'd0, exp_ready});
        chk({where, "_ovf"}, {31'd0, OVERFLOW}, {31'd0, exp_ovf});
    endtask

    // One conversion while capturing: strobe, 43-cycle conversion, DV level.
    task automatic convert(input logic [DW-1:0] val, input int hold, input bit done_too);
        wait_sample();
        tick();
        chk("sample_one_cycle", {31'd0, SAMPLE}, 32'd0);
        repeat (42) tick();
        ADC_DATA   = val;
        ADC_DV     = 1'b1;
        FRAME_DONE = done_too;
        tick();
        FRAME_DONE = 1'b0;
        exp_mem[exp_cnt] = stored(val);
        exp_cnt++;
        if (exp_cnt == LEN) begin
            exp_cnt   = 0;
            exp_ready = 1'b1;
        end
        check_flags("capture");
        repeat (hold - 1) tick();
        ADC_DV = 1'b0;
        tick();
    endtask

    task automatic run_frame(input int hold_lo, input int hold_hi, input bit done_last);
        for (int i = 0; i < LEN; i++) begin
            convert(vals[i], $urandom_range(hold_hi, hold_lo), done_last && (i == LEN - 1));
        end
    endtask

    // DV edge while a frame is held, optionally coinciding with the release.
    task automatic inject(input logic [DW-1:0] val, input bit done_too);
        ADC_DATA   = val;
        ADC_DV     = 1'b1;
        FRAME_DONE = done_too;
        tick();
        FRAME_DONE = 1'b0;
        if (done_too) begin
            since     = 0;
            exp_ready = 1'b0;
            exp_ovf   = 1'b0;
        end else if (exp_ready) begin
            exp_ovf = 1'b1;
        end
        check_flags("inject");
        tick();
        ADC_DV = 1'b0;
        tick();
        tick();
    endtask

    task automatic release_frame();
        FRAME_DONE = 1'b1;
        tick();
        FRAME_DONE = 1'b0;
        since     = 0;
        exp_ready = 1'b0;
        exp_ovf   = 1'b0;
        check_flags("release");
    endtask

    task automatic read_frame();
        int order [LEN];
        int j, t;
        for (int i = 0; i < LEN; i++) order[i] = i;
        for (int i = LEN - 1; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        for (int i = 0; i < LEN; i++) begin
            RD_ADDR = AW'(order[i]);
            tick();
            chk($sformatf("rd_data[%0d]", order[i]), {24'd0, RD_DATA}, {24'd0, exp_mem[order[i]]});
        end
    endtask

    task automatic random_vals();
        for (int i = 0; i < LEN; i++) vals[i] = DW'($urandom_range(255, 0));
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_sample", {31'd0, SAMPLE}, 32'd0);
        chk("rst_ready", {31'd0, FRAME_READY}, 32'd0);
        chk("rst_ovf", {31'd0, OVERFLOW}, 32'd0);
        chk("rst_rd_data", {24'd0, RD_DATA}, 32'd0);
        RESET = 1'b0;
        since = 0;

        // Pacing and fill with 10..17, single-cycle DV
        for (int i = 0; i < LEN; i++) vals[i] = DW'(10 + i);
        run_frame(1, 1, 1'b0);
        read_frame();

        // DV held 5 cycles per conversion
        release_frame();
        run_frame(5, 5, 1'b0);
        read_frame();

        // Overflow while holding, then release and refill with random data
        for (int k = 0; k < 3; k++) inject(8'd99, 1'b0);
        read_frame();
        repeat ($urandom_range(20, 5)) tick();
        check_flags("hold");
        release_frame();
        random_vals();
        run_frame(1, 8, 1'b0);
        read_frame();

        // FRAME_DONE on the final write is ignored
        release_frame();
        random_vals();
        run_frame(1, 8, 1'b1);
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(9, 1)) tick();
            check_flags("held_after_done_on_last");
        end
        read_frame();

        // DV edge together with release: sample dropped, overflow cleared
        inject(8'd55, 1'b1);

        // Reset after 4 captures with DV still high
        random_vals();
        for (int i = 0; i < 3; i++) convert(vals[i], $urandom_range(4, 1), 1'b0);
        wait_sample();
        repeat (43) tick();
        ADC_DATA = vals[3];
        ADC_DV   = 1'b1;
        tick();
        RESET = 1'b1;
        repeat (2) tick();
        chk("mid_rst_sample", {31'd0, SAMPLE}, 32'd0);
        chk("mid_rst_ready", {31'd0, FRAME_READY}, 32'd0);
        chk("mid_rst_ovf", {31'd0, OVERFLOW}, 32'd0);
        chk("mid_rst_rd_data", {24'd0, RD_DATA}, 32'd0);
        RESET     = 1'b0;
        since     = 0;
        exp_cnt   = 0;
        exp_ready = 1'b0;
        exp_ovf   = 1'b0;
        repeat (5) tick();
        check_flags("post_rst_dv_held");
        ADC_DV = 1'b0;

        // Fresh frame including offset-binary corner values
        random_vals();
        vals[0] = 8'h80;
        vals[1] = 8'h00;
        vals[2] = 8'hFF;
        run_frame(1, 8, 1'b0);
        read_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adc_frame_buffer.md
Name: adc_frame_buffer

Overview:
- Downstream neighbour of the ADC SPI reader; also generates that reader's SAMPLE strobe.
- Paces conversions at a fixed sample rate and captures each completed ADC word on the reader's data-valid into an on-chip frame memory of 2**ADDR_WIDTH samples.
- When the frame is full, raises FRAME_READY and holds the frame for the FFT stage.
- The FFT stage reads the frame by address and releases it with FRAME_DONE.

Parameters:
- DATA_WIDTH, 8, ADC word width; must equal the reader's NUMBER_OF_BITS.
- ADDR_WIDTH, 5, frame address width; FRAME_LEN = 2**ADDR_WIDTH samples (default 32).
- SAMPLE_PERIOD, 64, CLOCK cycles between SAMPLE pulses. Must exceed the reader's conversion time (43 cycles at CLKS_PER_HALF_BIT=2, NUMBER_OF_BITS=8) plus 2.

Ports:
- CLOCK  in  1  system clock, single clock domain
- RESET  in  1  synchronous, active-high reset
- ADC_DATA  in  DATA_WIDTH  reader DATA_OUT
- ADC_DV  in  1  reader DV; level, may stay high several cycles
- SAMPLE  out  1  one-cycle conversion-start strobe to the reader
- RD_ADDR  in  ADDR_WIDTH  FFT read address
- RD_DATA  out  DATA_WIDTH  frame word at RD_ADDR, registered
- FRAME_READY  out  1  frame full and held
- FRAME_DONE  in  1  one-cycle pulse from FFT releasing the frame
- OVERFLOW  out  1  sticky; a completed sample was dropped while holding a frame

Behaviour:
- Reset values (RESET high at a CLOCK edge):
  - state CAPTURE; wr_ptr 0; timer 0.
  - SAMPLE 0, FRAME_READY 0, OVERFLOW 0, RD_DATA 0.
  - DV edge register (dv_q) set to 1, so a DV already high at reset release is not captured.
  - Frame memory contents are not cleared.
  - Reset mid-frame discards the partial frame.
- Sample timer, CAPTURE state:
  - If timer == SAMPLE_PERIOD-1: timer <= 0 and SAMPLE <= 1. Otherwise timer <= timer+1 and SAMPLE <= 0.
  - First SAMPLE pulse is high in the cycle after the SAMPLE_PERIOD-th edge following reset release. Pulse spacing is exactly SAMPLE_PERIOD cycles.
- Sample timer, READY state: timer held at 0; SAMPLE 0.
- Capture:
  - dv_q <= ADC_DV every cycle. Capture event = ADC_DV & ~dv_q.
  - In CAPTURE, each capture event writes mem[wr_ptr] <= ADC_DATA and increments wr_ptr.
  - At most one write per DV rising edge, regardless of how long DV stays high.
- CAPTURE -> READY:
  - The capture event that writes index FRAME_LEN-1 switches the state to READY at the same edge.
  - wr_ptr wraps to 0 (natural ADDR_WIDTH wrap).
  - FRAME_READY is 1 from the next cycle.
- READY state:
  - A capture event (conversion already in flight) is not written, and sets OVERFLOW.
- READY -> CAPTURE:
  - FRAME_DONE high in READY: state CAPTURE, FRAME_READY 0, OVERFLOW cleared, timer restarts at 0 at that edge.
  - First new SAMPLE pulse follows SAMPLE_PERIOD cycles later.
- Simultaneous events:
  - FRAME_DONE in CAPTURE is ignored, including in the same cycle as the final write; the new frame is still held.
  - Capture event in the same READY cycle as FRAME_DONE: sample dropped, OVERFLOW ends 0 (clear wins), state CAPTURE.
- Read port:
  - RD_DATA <= mem[RD_ADDR] every cycle; 1-cycle latency, independent of state.
  - Contents are stable only while FRAME_READY=1.
- Memory: synchronous single write port, single read port; must map to iCE40 BRAM.
- Arithmetic: timer width clog2(SAMPLE_PERIOD); no saturation.

Optional Feature:
- Macro SIGNED_SAMPLES_EN.
- Defined: the written word is ADC_DATA with its MSB inverted (offset-binary to two's complement; 8'h80 -> 8'h00, 8'h00 -> 8'h80, 8'hFF -> 8'h7F), giving the FFT signed, DC-centred samples.
- Undefined: ADC_DATA is stored unmodified.
- No other behaviour changes.

Test Plan:
- Pacing: ADDR_WIDTH=3, SAMPLE_PERIOD=64, behavioural ADC returning 10,11,...,17 with DV after 43 cycles -> SAMPLE pulses exactly 64 cycles apart, first at cycle 64 after reset release. FRAME_READY rises 1 cycle after the 8th DV edge. Reading addresses 0..7 gives 10..17 with 1-cycle latency.
- DV held high 5 cycles per conversion -> one write per conversion only; frame still contains 10..17.
- FRAME_READY held, 3 extra DV edges injected with values 99 -> memory unchanged, OVERFLOW=1. FRAME_DONE pulse -> OVERFLOW=0, FRAME_READY=0, next SAMPLE 64 cycles later, new frame overwrites from address 0.
- FRAME_DONE asserted in the same cycle as the 8th write -> ignored; FRAME_READY=1 and stays 1 until a later FRAME_DONE.
- RESET asserted after 4 captures while DV is high -> outputs 0, no capture from the held DV. Next frame starts at address 0; FRAME_READY after 8 fresh samples.
- With SIGNED_SAMPLES_EN: ADC values 8'h80, 8'h00, 8'hFF -> stored 8'h00, 8'h80, 8'h7F. Without it, stored unchanged.
